// File: rtl/demultiplexer.sv
// ---------------------------------------------------------------------------
// demultiplexer
//   Steers one WIDTH-bit word per accepted transfer to one of four output
//   channels, each backed by a one-entry buffer with its own valid/ready
//   handshake. Counterpart to the 4:1 multiplexer in the register-file
//   datapath.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : producer offers din/sig this cycle
//   in_ready  : selected channel can take the word (combinational)
//   sig       : destination channel (00->ch1 .. 11->ch4)
//   din       : data word
//   o_1..o_4  : channel buffer contents (registered, retained when empty)
//   o_valid   : bit k-1 set when channel k holds an undelivered word
//   o_ready   : bit k-1 set when consumer k takes the word this cycle
// ---------------------------------------------------------------------------
module demultiplexer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sig,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] o_1,
    output logic [WIDTH-1:0] o_2,
    output logic [WIDTH-1:0] o_3,
    output logic [WIDTH-1:0] o_4,
    output logic [3:0]       o_valid,
    input  logic [3:0]       o_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t        r_state [4];
    ch_state_t        w_state_nxt [4];
    logic [WIDTH-1:0] r_data [4];

    logic [3:0] w_full;
    logic [3:0] w_sel;
    logic [3:0] w_drn;
    logic [3:0] w_load;
    logic       w_acc;

    // Selected channel is ready if it is empty or draining this same cycle,
    // which is what allows back-to-back words to one channel.
    always_comb begin
        w_full      = '0;
        w_drn       = '0;
        w_load      = '0;
        w_sel       = 4'b0001 << sig;
        for (int unsigned k = 0; k < 4; k++) begin
            w_full[k] = (r_state[k] == FULL);
        end
        in_ready = !w_full[sig] || o_ready[sig];
        w_acc    = in_valid && in_ready;
        for (int unsigned k = 0; k < 4; k++) begin
            w_drn[k]  = w_full[k] && o_ready[k];
            w_load[k] = w_acc && w_sel[k];
        end
    end

    // Per-channel next state; an accept into a FULL channel only happens
    // when it also drains, so FULL+load stays FULL.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            w_state_nxt[k] = r_state[k];
            case (r_state[k])
                EMPTY:   if (w_load[k]) w_state_nxt[k] = FULL;
                FULL:    if (w_drn[k] && !w_load[k]) w_state_nxt[k] = EMPTY;
                default: w_state_nxt[k] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < 4; k++) begin
                r_state[k] <= EMPTY;
                r_data[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                r_state[k] <= w_state_nxt[k];
                if (w_load[k]) begin
                    r_data[k] <= din;
                end
            end
        end
    end

    assign o_valid = w_full;
    assign o_1     = r_data[0];
    assign o_2     = r_data[1];
    assign o_3     = r_data[2];
    assign o_4     = r_data[3];

endmodule

// File: doc/demultiplexer.md
# demultiplexer

Four-way demultiplexer with per-channel buffering, the counterpart to the 4:1 `mutliplexer` in the register-file datapath. It accepts one 32-bit word per transfer with a 2-bit select `sig` over a valid/ready handshake and steers the word to one of four output channels. Each output channel holds the word in a one-entry buffer with its own valid/ready handshake. It fans a single result bus out to four independent consumers, such as register-file write ports or bank write buffers.

## Interface
- `WIDTH`, default 32, data width of the input and of every output channel.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  producer offers `din`/`sig` this cycle.
- `in_ready`  output  1  block accepts the offered word this cycle (combinational).
- `sig`  input  2  destination channel: 00→ch1, 01→ch2, 10→ch3, 11→ch4.
- `din`  input  WIDTH  data word.
- `o_1`, `o_2`, `o_3`, `o_4`  output  WIDTH each  channel buffer contents (registered).
- `o_valid`  output  4  bit k-1 set means channel k holds an undelivered word.
- `o_ready`  input  4  bit k-1 set means consumer k takes the word this cycle.

## Operation
- **Per-channel state machine:** k ∈ 1..4, flag `full[k]`.
  - States: EMPTY (`full`=0), FULL (`full`=1).
  - `o_valid[k-1]` = `full[k]`.
- **Accept:** the offered word is accepted when `in_valid` && `in_ready`. Call this `acc`.
  - `in_ready` = !`full[sel]` || `o_ready[sel-1]`, where sel is the channel decoded from `sig`.
  - A full channel can therefore take a new word in the same cycle it drains.
- **Drain:** channel k drains when `o_valid[k-1]` && `o_ready[k-1]`. Call this `drn[k]`.
- **Transitions for channel k:**
  - EMPTY, `acc` to k → FULL; `o_k` ← `din`.
  - FULL, `drn[k]` with no `acc` to k → EMPTY; `o_k` keeps its last value.
  - FULL, `drn[k]` and `acc` to k in the same cycle → stays FULL; `o_k` ← `din`.
  - FULL, no `drn[k]` → stays FULL; any `acc` to k is refused (`in_ready`=0). `o_k` is unchanged.
- **Channel independence:** channels do not interact.
  - An accept to one channel and drains on any other channels may all occur in the same cycle.
  - At most one accept occurs per cycle.
- **`sig` when idle:** `sig` and `din` are ignored when `in_valid`=0. `in_ready` still reflects the channel selected by `sig`.
- **Data path:** no arithmetic and no width conversion. Words pass bit-exact.
- **Outputs while EMPTY:** `o_k` retains the last written value (no clearing). Consumers qualify `o_k` with `o_valid` only.

## Timing
- **Reset:** when `rst`=1 at a clock edge:
  - `full` ← 0000, `o_valid` = 0000.
  - `o_1`..`o_4` ← 0.
  - `in_ready` = 1 after reset, independent of `o_ready`.
- **Reset mid-operation:** buffered words are discarded. An `acc` in the same cycle as `rst` is lost, and reset wins.
- **Latency:** a word accepted at edge n appears on `o_k` with `o_valid[k-1]`=1 after edge n, i.e. one cycle later.
- **Throughput:** one word per cycle sustained to any single channel whose consumer holds `o_ready`=1 continuously. This includes back-to-back words to the same channel.
- **Back-pressure:** `in_ready` depends combinationally on `sig` and `o_ready`. `in_valid` must not depend combinationally on `in_ready`.
- **Producer obligation:** once `in_valid`=1 with a given `sig`/`din`, the producer holds them until accepted.
- **Consumer side:** `o_valid` never drops without a drain or reset. `o_k` is stable while `o_valid`=1 and not drained.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `in_valid`=1 → `o_valid`=0000, all `o_k`=0, `in_ready`=1 after release.
- **Route to each channel:** `o_ready`=1111, `in_valid`=1, `din`=FFFFFFFF/00000000/FFFF0000/0000FFFF with `sig`=00/01/10/11 on consecutive cycles.
  - Each word appears on `o_1`/`o_2`/`o_3`/`o_4` respectively one cycle after its accept.
  - `o_valid` shows a single bit per cycle: 0001, 0010, 0100, 1000.
- **Back-pressure:** `o_ready`=0000; send A5A5A5A5 to ch3, then 5A5A5A5A to ch3.
  - Second word is held off: `in_ready`=0, `o_3` stays A5A5A5A5.
  - Raise `o_ready[2]` → second word accepted that cycle; `o_3`=5A5A5A5A next cycle, `o_valid[2]` stays 1.
- **Parallel buffering:** `o_ready`=0000; fill all four channels with 1,2,3,4.
  - `o_valid`=1111, `in_ready`=0 for every `sig`.
  - Raise `o_ready`=0101 → ch1 and ch3 drain, `o_valid`=1010.
- **Mid-operation reset:** with ch2 full (DEADBEEF) and a new word being accepted to ch4, assert `rst` → after the edge `o_valid`=0000, `o_2`=0, `o_4`=0.
- **Idle select changes:** toggle `sig` through all values with `in_valid`=0 → no state change; `o_k` and `o_valid` are unchanged.
